// File: rtl/mips_pkg.sv
// mips_pkg: shared opcode, pc_source, vector and FSM definitions for the next-PC controller.
// Revision: 1.0
`default_nettype none

package mips_pkg;

  localparam logic [5:0] c_OP_RTYPE = 6'h00;
  localparam logic [5:0] c_OP_J     = 6'h02;
  localparam logic [5:0] c_OP_JAL   = 6'h03;
  localparam logic [5:0] c_OP_BEQ   = 6'h04;
  localparam logic [5:0] c_OP_BNE   = 6'h05;
  localparam logic [5:0] c_OP_BLE   = 6'h06;
  localparam logic [5:0] c_OP_BGT   = 6'h07;
  localparam logic [5:0] c_OP_RTE   = 6'h10;

  localparam logic [5:0] c_FN_JR    = 6'h08;

  localparam logic [2:0] c_SRC_ALU    = 3'd0;
  localparam logic [2:0] c_SRC_ALUOUT = 3'd1;
  localparam logic [2:0] c_SRC_JUMP   = 3'd2;
  localparam logic [2:0] c_SRC_EPC    = 3'd3;
  localparam logic [2:0] c_SRC_VEC    = 3'd4;

  localparam logic [7:0] c_VEC_INVALID = 8'd253;
  localparam logic [7:0] c_VEC_OVF     = 8'd254;
  localparam logic [7:0] c_VEC_DIV0    = 8'd255;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EXC_WAIT = 2'd1,
    ST_EXC_LOAD = 2'd2
  } state_e;

  function automatic logic opcode_valid(input logic [5:0] op);
    case (op)
      6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
      6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0E, 6'h0F, 6'h10,
      6'h20, 6'h21, 6'h23, 6'h28, 6'h29, 6'h2B: return 1'b1;
      default:                                   return 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_classify.sv
// instr_classify: combinational mapping of decoded fields and ALU flags to next-PC action.
// Revision: 1.0
`default_nettype none

module instr_classify
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       gt,
  input  logic       ovf,
  input  logic       div0,
  output logic       is_exc,
  output logic [7:0] vector,
  output logic [2:0] source,
  output logic       link,
  output logic       pass_a
);

  logic       w_valid;
  logic       w_taken;

  assign w_valid = opcode_valid(opcode);

  always_comb begin
    w_taken = 1'b0;
    case (opcode)
      c_OP_BEQ: w_taken = zero;
      c_OP_BNE: w_taken = ~zero;
      c_OP_BLE: w_taken = ~gt;
      c_OP_BGT: w_taken = gt;
      default:  w_taken = 1'b0;
    endcase
  end

  // Invalid opcode outranks ovf, and ovf outranks div0.
  always_comb begin
    is_exc = 1'b1;
    vector = 8'd0;
    if (!w_valid)  vector = c_VEC_INVALID;
    else if (ovf)  vector = c_VEC_OVF;
    else if (div0) vector = c_VEC_DIV0;
    else           is_exc = 1'b0;
  end

  always_comb begin
    source = c_SRC_ALU;
    link   = 1'b0;
    pass_a = 1'b0;
    case (opcode)
      c_OP_RTE: source = c_SRC_EPC;
      c_OP_RTYPE: begin
        if (funct == c_FN_JR) pass_a = 1'b1;
      end
      c_OP_J:   source = c_SRC_JUMP;
      c_OP_JAL: begin
        source = c_SRC_JUMP;
        link   = 1'b1;
      end
      c_OP_BEQ, c_OP_BNE, c_OP_BLE, c_OP_BGT: begin
        source = w_taken ? c_SRC_ALUOUT : c_SRC_ALU;
      end
      default: source = c_SRC_ALU;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/pc_source_ctrl.sv
// pc_source_ctrl: multicycle MIPS next-PC controller with exception EPC/vector sequencing.
// Revision: 1.0
`default_nettype none

module pc_source_ctrl
  import mips_pkg::*;
#(
  parameter int MEM_LAT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       gt,
  input  logic       ovf,
  input  logic       div0,
  output logic [2:0] pc_source,
  output logic       pc_write,
  output logic       epc_write,
  output logic       link_write,
  output logic       alu_pass_a,
  output logic [7:0] exc_vec,
  output logic       busy,
  output logic       done
);

  // The EPC-capture cycle is the first of the MEM_LAT wait cycles.
  localparam logic [3:0] c_CNT_INIT = 4'(MEM_LAT - 1);

  logic       w_is_exc;
  logic [7:0] w_vector;
  logic [2:0] w_source;
  logic       w_link;
  logic       w_pass_a;

  state_e     r_state;
  logic [3:0] r_cnt;
  logic [2:0] r_pc_source;
  logic       r_pc_write;
  logic       r_epc_write;
  logic       r_link_write;
  logic       r_alu_pass_a;
  logic [7:0] r_exc_vec;
  logic       r_busy;
  logic       r_done;

  instr_classify u_classify (
    .opcode (opcode),
    .funct  (funct),
    .zero   (zero),
    .gt     (gt),
    .ovf    (ovf),
    .div0   (div0),
    .is_exc (w_is_exc),
    .vector (w_vector),
    .source (w_source),
    .link   (w_link),
    .pass_a (w_pass_a)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 4'd0;
      r_pc_source  <= c_SRC_ALU;
      r_pc_write   <= 1'b0;
      r_epc_write  <= 1'b0;
      r_link_write <= 1'b0;
      r_alu_pass_a <= 1'b0;
      r_exc_vec    <= 8'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_pc_write   <= 1'b0;
      r_epc_write  <= 1'b0;
      r_link_write <= 1'b0;
      r_alu_pass_a <= 1'b0;
      r_done       <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req) begin
            if (w_is_exc) begin
              r_state     <= ST_EXC_WAIT;
              r_cnt       <= c_CNT_INIT;
              r_epc_write <= 1'b1;
              r_exc_vec   <= w_vector;
              r_busy      <= 1'b1;
            end else begin
              r_pc_source  <= w_source;
              r_pc_write   <= 1'b1;
              r_done       <= 1'b1;
              r_link_write <= w_link;
              r_alu_pass_a <= w_pass_a;
            end
          end
        end
        ST_EXC_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state     <= ST_EXC_LOAD;
            r_pc_source <= c_SRC_VEC;
            r_pc_write  <= 1'b1;
            r_done      <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_EXC_LOAD: begin
          r_state   <= ST_IDLE;
          r_busy    <= 1'b0;
          r_exc_vec <= 8'd0;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_busy    <= 1'b0;
          r_exc_vec <= 8'd0;
        end
      endcase
    end
  end

  assign pc_source  = r_pc_source;
  assign pc_write   = r_pc_write;
  assign epc_write  = r_epc_write;
  assign link_write = r_link_write;
  assign alu_pass_a = r_alu_pass_a;
  assign exc_vec    = r_exc_vec;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

`default_nettype wire

// File: tb/tb_pc_source_ctrl.sv
// tb_pc_source_ctrl: directed vector table plus hand-written exception/reset sequences.
// Revision: 1.0
`default_nettype none

module tb_pc_source_ctrl;

  localparam int LAT = 2;

  logic       clk;
  logic       reset;
  logic       req;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       gt;
  logic       ovf;
  logic       div0;
  logic [2:0] pc_source;
  logic       pc_write;
  logic       epc_write;
  logic       link_write;
  logic       alu_pass_a;
  logic [7:0] exc_vec;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_err = 0;

  pc_source_ctrl #(.MEM_LAT(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .gt         (gt),
    .ovf        (ovf),
    .div0       (div0),
    .pc_source  (pc_source),
    .pc_write   (pc_write),
    .epc_write  (epc_write),
    .link_write (link_write),
    .alu_pass_a (alu_pass_a),
    .exc_vec    (exc_vec),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    logic       g;
    logic [2:0] src;
    logic       lnk;
    logic       pa;
  } vec_t;

  vec_t vt[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic g, input logic o, input logic d);
    req    = r;
    opcode = op;
    funct  = fn;
    zero   = z;
    gt     = g;
    ovf    = o;
    div0   = d;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " pc_source"},  32'(pc_source),  32'd0);
    chk({tag, " pc_write"},   32'(pc_write),   32'd0);
    chk({tag, " epc_write"},  32'(epc_write),  32'd0);
    chk({tag, " link_write"}, 32'(link_write), 32'd0);
    chk({tag, " alu_pass_a"}, 32'(alu_pass_a), 32'd0);
    chk({tag, " exc_vec"},    32'(exc_vec),    32'd0);
    chk({tag, " busy"},       32'(busy),       32'd0);
    chk({tag, " done"},       32'(done),       32'd0);
  endtask

  // Full exception sequence with no interfering req.
  task automatic run_exc(input string tag, input logic [5:0] op, input logic [5:0] fn,
                         input logic o, input logic d, input logic [7:0] vec, input logic [2:0] prev_src);
    @(negedge clk);
    drive(1'b1, op, fn, 1'b0, 1'b0, o, d);
    @(posedge clk); #1;
    chk({tag, " epc_write"}, 32'(epc_write), 32'd1);
    chk({tag, " exc_vec"},   32'(exc_vec),   32'(vec));
    chk({tag, " busy"},      32'(busy),      32'd1);
    chk({tag, " pc_write@epc"}, 32'(pc_write), 32'd0);
    chk({tag, " pc_source held"}, 32'(pc_source), 32'(prev_src));
    @(negedge clk);
    req = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      @(posedge clk); #1;
      if (k < LAT) begin
        chk({tag, " pc_write wait"}, 32'(pc_write), 32'd0);
      end else begin
        chk({tag, " pc_write load"}, 32'(pc_write), 32'd1);
        chk({tag, " done load"},     32'(done),     32'd1);
        chk({tag, " pc_source load"}, 32'(pc_source), 32'd4);
        chk({tag, " exc_vec load"},  32'(exc_vec),  32'(vec));
      end
    end
    @(posedge clk); #1;
    chk({tag, " busy end"},    32'(busy),    32'd0);
    chk({tag, " exc_vec end"}, 32'(exc_vec), 32'd0);
  endtask

  initial begin
    int pw_seen;

    vt[0]  = '{6'h23, 6'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0}; // lw
    vt[1]  = '{6'h04, 6'h00, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0}; // beq taken
    vt[2]  = '{6'h06, 6'h00, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0}; // ble not taken
    vt[3]  = '{6'h07, 6'h00, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0}; // bgt taken
    vt[4]  = '{6'h03, 6'h00, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0}; // jal
    vt[5]  = '{6'h00, 6'h08, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1}; // jr
    vt[6]  = '{6'h05, 6'h00, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0}; // bne taken
    vt[7]  = '{6'h05, 6'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0}; // bne not taken
    vt[8]  = '{6'h04, 6'h00, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0}; // beq not taken
    vt[9]  = '{6'h06, 6'h00, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0}; // ble taken
    vt[10] = '{6'h07, 6'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0}; // bgt not taken
    vt[11] = '{6'h00, 6'h09, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0}; // R-type, not jr
    vt[12] = '{6'h02, 6'h00, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0}; // j
    vt[13] = '{6'h2B, 6'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0}; // sw
    vt[14] = '{6'h10, 6'h00, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0}; // rte

    reset = 1'b1;
    drive(1'b0, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    // Back-to-back requests, one per cycle.
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(1'b1, vt[i].op, vt[i].fn, vt[i].z, vt[i].g, 1'b0, 1'b0);
      @(posedge clk); #1;
      chk($sformatf("v%0d pc_source", i),  32'(pc_source),  32'(vt[i].src));
      chk($sformatf("v%0d pc_write", i),   32'(pc_write),   32'd1);
      chk($sformatf("v%0d done", i),       32'(done),       32'd1);
      chk($sformatf("v%0d link_write", i), 32'(link_write), 32'(vt[i].lnk));
      chk($sformatf("v%0d alu_pass_a", i), 32'(alu_pass_a), 32'(vt[i].pa));
      chk($sformatf("v%0d epc_write", i),  32'(epc_write),  32'd0);
      chk($sformatf("v%0d busy", i),       32'(busy),       32'd0);
    end

    @(negedge clk);
    req = 1'b0;
    @(posedge clk); #1;
    chk("idle pc_write",   32'(pc_write),   32'd0);
    chk("idle done",       32'(done),       32'd0);
    chk("idle link_write", 32'(link_write), 32'd0);
    chk("idle alu_pass_a", 32'(alu_pass_a), 32'd0);
    chk("idle pc_source held", 32'(pc_source), 32'd3);

    // ovf and div0 together, with requests during the wait and load cycles.
    @(negedge clk);
    drive(1'b1, 6'h00, 6'h20, 1'b0, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    chk("exc1 epc_write", 32'(epc_write), 32'd1);
    chk("exc1 exc_vec",   32'(exc_vec),   32'd254);
    chk("exc1 busy",      32'(busy),      32'd1);
    chk("exc1 pc_source held", 32'(pc_source), 32'd3);
    @(negedge clk);
    drive(1'b1, 6'h23, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("exc1 busy-req pc_write",  32'(pc_write),  32'd0);
    chk("exc1 busy-req epc_write", 32'(epc_write), 32'd0);
    chk("exc1 wait busy",          32'(busy),      32'd1);
    @(negedge clk);
    req = 1'b0;
    @(posedge clk); #1;
    chk("exc1 load pc_write",  32'(pc_write),  32'd1);
    chk("exc1 load done",      32'(done),      32'd1);
    chk("exc1 load pc_source", 32'(pc_source), 32'd4);
    chk("exc1 load busy",      32'(busy),      32'd1);
    chk("exc1 load exc_vec",   32'(exc_vec),   32'd254);
    @(negedge clk);
    drive(1'b1, 6'h23, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("exc1 end busy",            32'(busy),      32'd0);
    chk("exc1 end exc_vec",         32'(exc_vec),   32'd0);
    chk("exc1 load-req dropped",    32'(pc_write),  32'd0);
    chk("exc1 load-req no epc",     32'(epc_write), 32'd0);
    @(negedge clk);
    drive(1'b1, 6'h04, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("post-exc accept pc_write",  32'(pc_write),  32'd1);
    chk("post-exc accept pc_source", 32'(pc_source), 32'd1);
    @(negedge clk);
    req = 1'b0;

    run_exc("div0",      6'h00, 6'h1A, 1'b0, 1'b1, 8'd255, 3'd1);
    run_exc("addi ovf",  6'h08, 6'h00, 1'b1, 1'b0, 8'd254, 3'd4);
    run_exc("inv 0x11",  6'h11, 6'h00, 1'b0, 1'b0, 8'd253, 3'd4);

    // Invalid opcode with ovf, aborted by reset mid-sequence.
    @(negedge clk);
    drive(1'b1, 6'h3F, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("abort exc_vec",   32'(exc_vec),   32'd253);
    chk("abort epc_write", 32'(epc_write), 32'd1);
    @(negedge clk);
    req = 1'b0;
    @(posedge clk); #1;
    chk("abort wait busy", 32'(busy), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_all_zero("async reset");
    @(negedge clk);
    reset = 1'b0;
    pw_seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (pc_write) pw_seen++;
    end
    chk("abort no pc_write", 32'(pw_seen), 32'd0);
    chk("abort busy",        32'(busy),    32'd0);

    @(negedge clk);
    drive(1'b1, 6'h02, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("resume pc_write",  32'(pc_write),  32'd1);
    chk("resume pc_source", 32'(pc_source), 32'd2);
    @(negedge clk);
    req = 1'b0;
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pc_source_ctrl.md
# pc_source_ctrl

Sequential next-PC controller for the multicycle MIPS core. It generates the 3-bit `pc_source` select and the `pc_write` strobe that drive the PC-source multiplexer and the PC register. Its inputs are the decoded instruction fields and the ALU flags. It resolves jumps, taken and not-taken branches, and `rte`. For exceptions, it sequences EPC capture, the exception-vector memory read wait, and the final load of the vector into PC.

## Interface
Parameters:
- `MEM_LAT`, default 2: cycles from `exc_vec` valid to vector byte valid on mux input 4; legal range 1..15.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high; all outputs return to reset values immediately.
- `req`  in  1  one-cycle pulse: resolve next PC for the current instruction.
- `opcode`  in  6  instruction[31:26], sampled on `req`.
- `funct`  in  6  instruction[5:0], sampled on `req`.
- `zero`  in  1  ALU A==B, sampled on `req`.
- `gt`  in  1  ALU A>B signed, sampled on `req`.
- `ovf`  in  1  arithmetic overflow of current instruction, sampled on `req`.
- `div0`  in  1  divide-by-zero of current instruction, sampled on `req`.
- `pc_source`  out  3  mux select: 0 ALU result, 1 ALUOut (branch target), 2 jump target, 3 EPC, 4 vector byte; reset 0.
- `pc_write`  out  1  one-cycle PC load strobe; reset 0.
- `epc_write`  out  1  one-cycle EPC capture strobe; reset 0.
- `link_write`  out  1  one-cycle $ra write strobe, for `jal` only; reset 0.
- `alu_pass_a`  out  1  ALU passes A, for `jr`; valid with `pc_write`; reset 0.
- `exc_vec`  out  8  exception vector address; reset 0.
- `busy`  out  1  exception sequence in progress; reset 0.
- `done`  out  1  one-cycle pulse, coincident with every `pc_write`; reset 0.

## Operation
Classification of a `req`, in priority order:
- Exception, first match wins:
  - invalid opcode → vector 253
  - `ovf` → vector 254
  - `div0` → vector 255
- `rte` (opcode 0x10) → source 3.
- `jr` (opcode 0x00, funct 0x08) → source 0, with `alu_pass_a`=1.
- `j` (0x02) → source 2; `jal` (0x03) → source 2, with `link_write`=1.
- Branches use source 1 when taken, else source 0:
  - `beq` (0x04): taken if `zero`
  - `bne` (0x05): taken if !`zero`
  - `ble` (0x06): taken if !`gt`
  - `bgt` (0x07): taken if `gt`
- Anything else → source 0 (sequential PC+4).

Valid opcode set: 0x00–0x0A, 0x0C, 0x0E, 0x0F, 0x10, 0x20, 0x21, 0x23, 0x28, 0x29, 0x2B.

FSM states:
- IDLE
  - `req` with no exception → stay in IDLE, issue the resolve pulse.
  - `req` with exception → EXC_WAIT.
- EXC_WAIT: counter runs MEM_LAT cycles → EXC_LOAD.
- EXC_LOAD: one cycle → IDLE.

Output rules:
- `pc_source` is registered and holds its last value between updates.
- `exc_vec` holds its value from the `epc_write` cycle through the EXC_LOAD cycle, then returns to 0.
- `req` while `busy`=1 is ignored: no state change, no strobes.

## Timing
All outputs are registered. `req` is sampled at edge T.
- Non-exception: at T+1, `pc_write`=1, `done`=1, and `pc_source` is valid. `link_write` and `alu_pass_a` are asserted in the same cycle where applicable. All strobes clear at T+2. Back-to-back `req` every cycle is supported.
- Exception:
  - T+1: `epc_write`=1, `exc_vec` valid, `busy`=1. `pc_source` is unchanged.
  - T+1+MEM_LAT (EXC_LOAD): `pc_source`=4, `pc_write`=1, `done`=1.
  - T+2+MEM_LAT: `busy`=0 and `exc_vec`=0; the next `req` is accepted from this edge.
- Simultaneous `ovf` and `div0` → vector 254.
- An invalid opcode with `ovf` set → vector 253.
- Reset asserted mid-exception → IDLE with all outputs at reset values. No `pc_write` issues for the aborted sequence; an `epc_write` already issued is not undone.
- `req` arriving in the EXC_LOAD cycle is dropped.

## Structure
- Shared package `mips_pkg`:
  - opcode and funct constants
  - `pc_source` encodings 0..4
  - vector constants 253/254/255
  - valid-opcode list
  - FSM state encoding
- One natural sub-module, `instr_classify`: a combinational block mapping (`opcode`, `funct`, `zero`, `gt`, `ovf`, `div0`) to {is_exc, vector, source, link, pass_a}.
- The FSM, latency counter and output registers live in `pc_source_ctrl`.

## Test plan
- Reset, then `req` with `opcode`=0x23 (lw) → T+1: `pc_write`=1, `pc_source`=0, `done`=1; T+2: all strobes 0.
- `req` `beq` with `zero`=1 → T+1: `pc_source`=1. Then `req` `ble` with `gt`=1 → T+1: `pc_source`=0. Then `req` `bgt` with `gt`=1 → T+1: `pc_source`=1.
- `req` `jal` → T+1: `pc_source`=2, `link_write`=1. Next cycle `req` `jr` (funct 0x08) → T+1: `pc_source`=0, `alu_pass_a`=1.
- MEM_LAT=2, `req` `add` with `ovf`=1 and `div0`=1:
  - T+1: `epc_write`=1, `exc_vec`=254, `busy`=1.
  - T+3: `pc_write`=1, `pc_source`=4.
  - T+4: `busy`=0, `exc_vec`=0.
  - A `req` issued at T+2 produces no strobe.
- `req` with `opcode`=0x3F and `ovf`=1 → `exc_vec`=253. `reset` pulsed at T+2 → all outputs 0 immediately, and no `pc_write` follows.
- `req` `rte` (0x10) → T+1: `pc_source`=3, `pc_write`=1.
